// File: rtl/divider_pkg.sv
// ============================================================================
//  Module  : divider_pkg
//  Brief   : Shared constants and FSM encoding for the divider result serializer.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package divider_pkg;

  localparam int DATA_WIDTH       = 65;
  localparam int OUT_WIDTH        = 8;
  localparam int PAYLOAD_WIDTH    = DATA_WIDTH - 1;
  localparam int BEATS_PER_FRAME  = PAYLOAD_WIDTH / OUT_WIDTH;
  localparam int SIGN_BIT         = 64;
  localparam int BUFFER_DEPTH     = 4;
  localparam int LOG_BUFFER_DEPTH = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/res_fifo.sv
// ============================================================================
//  Module  : res_fifo
//  Brief   : Synchronous FIFO; full/empty decoded from wrap-bit pointers.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module res_fifo
  import divider_pkg::*;
#(
  parameter int WIDTH     = divider_pkg::DATA_WIDTH,
  parameter int DEPTH     = divider_pkg::BUFFER_DEPTH,
  parameter int PTR_WIDTH = divider_pkg::LOG_BUFFER_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [PTR_WIDTH-1:0] count
);

  localparam int ADDR_WIDTH = PTR_WIDTH - 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 do_wr;
  logic                 do_rd;

  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];
  // Same slot with opposite wrap bits means the writer lapped the reader.
  assign full    = (wr_ptr[PTR_WIDTH-1] != rd_ptr[PTR_WIDTH-1]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;

endmodule

`default_nettype wire

// File: rtl/result_byte_serializer.sv
// ============================================================================
//  Module  : result_byte_serializer
//  Brief   : Buffers 65-bit divider results and emits each as an 8-byte frame, LSB first.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module result_byte_serializer
  import divider_pkg::*;
#(
  parameter int DATA_WIDTH       = divider_pkg::DATA_WIDTH,
  parameter int BUFFER_DEPTH     = divider_pkg::BUFFER_DEPTH,
  parameter int LOG_BUFFER_DEPTH = divider_pkg::LOG_BUFFER_DEPTH,
  parameter int OUT_WIDTH        = divider_pkg::OUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic [OUT_WIDTH-1:0]  data_out_out,
  output logic                  pull_out,
  output logic                  sign_out,
  output logic                  drop_err
);

  localparam int PAYLOAD_W = DATA_WIDTH - 1;
  localparam int BEATS     = PAYLOAD_W / OUT_WIDTH;
  localparam int CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic                        push;
  logic                        pop;
  logic                        full;
  logic                        empty;
  logic [DATA_WIDTH-1:0]       head;
  logic [LOG_BUFFER_DEPTH-1:0] fifo_count;

  state_t                      state, state_nxt;
  logic [CNT_W-1:0]            beat, beat_nxt;
  logic [PAYLOAD_W-1:0]        shreg, shreg_nxt;
  logic [OUT_WIDTH-1:0]        byte_nxt;
  logic                        pull_nxt;
  logic                        sign_nxt;
  logic                        frame_done;

  assign push      = res_valid & ~full;
  assign res_ready = ~full;

  res_fifo #(
    .WIDTH     (DATA_WIDTH),
    .DEPTH     (BUFFER_DEPTH),
    .PTR_WIDTH (LOG_BUFFER_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (push),
    .wr_data (res_data),
    .rd      (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // The cycle after the last byte behaves like IDLE so frames can run back-to-back.
  assign frame_done = (state == IDLE) || (beat == LAST_BEAT);

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    shreg_nxt = shreg;
    byte_nxt  = data_out_out;
    pull_nxt  = 1'b0;
    sign_nxt  = sign_out;
    pop       = 1'b0;
    if (frame_done && !empty) begin
      pop       = 1'b1;
      shreg_nxt = head[PAYLOAD_W-1:0];
      byte_nxt  = head[OUT_WIDTH-1:0];
      pull_nxt  = 1'b1;
      sign_nxt  = head[DATA_WIDTH-1];
      beat_nxt  = '0;
      state_nxt = SEND;
    end else if (!frame_done) begin
      shreg_nxt = shreg >> OUT_WIDTH;
      byte_nxt  = shreg[2*OUT_WIDTH-1:OUT_WIDTH];
      beat_nxt  = beat + 1'b1;
    end else begin
      state_nxt = IDLE;
      byte_nxt  = '0;
      sign_nxt  = 1'b0;
      beat_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= '0;
      shreg        <= '0;
      data_out_out <= '0;
      pull_out     <= 1'b0;
      sign_out     <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      beat         <= beat_nxt;
      shreg        <= shreg_nxt;
      data_out_out <= byte_nxt;
      pull_out     <= pull_nxt;
      sign_out     <= sign_nxt;
      if (res_valid && full) drop_err <= 1'b1;
    end
  end

  a_full_matches_count : assert property (@(posedge clk) disable iff (rst)
    full == (fifo_count == LOG_BUFFER_DEPTH'(BUFFER_DEPTH)));

endmodule

`default_nettype wire

// File: tb/tb_result_byte_serializer.sv
// ============================================================================
//  Module  : tb_result_byte_serializer
//  Brief   : Self-checking bench with cycle model and frame scoreboard.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_result_byte_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0;
  logic [64:0] res_data = '0;
  logic        res_ready;
  logic [7:0]  data_out_out;
  logic        pull_out;
  logic        sign_out;
  logic        drop_err;

  result_byte_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .data_out_out (data_out_out),
    .pull_out     (pull_out),
    .sign_out     (sign_out),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [64:0] mq[$];
  logic [64:0] sb[$];
  bit          m_busy = 0;
  int          m_beat = 0;
  logic [63:0] m_frame = '0;
  logic [7:0]  m_data = '0;
  bit          m_pull = 0, m_sign = 0, m_drop = 0, m_ready = 1;
  bit          m_last_acc = 0;
  bit          flush = 0;
  bit          started = 0;
  bit          acc, popping;
  logic [64:0] f;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete(); sb.delete();
      m_busy = 0; m_beat = 0; m_data = '0; m_pull = 0; m_sign = 0; m_drop = 0;
      m_last_acc = 0; flush = 1;
    end else begin
      acc     = res_valid && (mq.size() < 4);
      popping = (!m_busy || m_beat == 7) && (mq.size() > 0);
      if (res_valid && !acc) m_drop = 1;
      if (popping) begin
        f = mq.pop_front();
        m_frame = f[63:0]; m_sign = f[64]; m_data = f[7:0];
        m_pull = 1; m_beat = 0; m_busy = 1;
      end else if (m_busy && m_beat < 7) begin
        m_beat++;
        m_data = m_frame[8*m_beat +: 8];
        m_pull = 0;
      end else begin
        m_busy = 0; m_beat = 0; m_data = '0; m_pull = 0; m_sign = 0;
      end
      if (acc) begin
        mq.push_back(res_data);
        sb.push_back(res_data);
      end
      m_last_acc = acc;
    end
    m_ready = (mq.size() < 4);
  end

  // Monitor: cycle comparison plus frame reassembly against the scoreboard
  bit          coll = 0;
  int          ccnt = 0;
  logic [63:0] asm_frame = '0;
  bit          fsign = 0;
  logic [64:0] exp_frame;

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("ready", res_ready, m_ready);
      check("data", data_out_out, m_data);
      check("pull", pull_out, m_pull);
      check("sign", sign_out, m_sign);
      check("drop", drop_err, m_drop);
      if (flush) begin
        coll = 0; ccnt = 0; flush = 0;
      end
      if (pull_out) begin
        if (coll) check("frame_short", ccnt, 8);
        coll = 1; ccnt = 0; asm_frame = '0; fsign = sign_out;
      end
      if (coll) begin
        if (ccnt > 0) begin
          check("beat_pull", pull_out, 0);
          check("sign_hold", sign_out, fsign);
        end
        asm_frame[8*ccnt +: 8] = data_out_out;
        ccnt++;
        if (ccnt == 8) begin
          coll = 0;
          if (sb.size() == 0) check("sb_underflow", 0, 1);
          else begin
            exp_frame = sb.pop_front();
            check("frame", {fsign, asm_frame}, exp_frame);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    res_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Holds data until the model reports acceptance, i.e. retries while full.
  task automatic send(input logic [64:0] d);
    int tries = 0;
    res_valid = 1'b1;
    res_data  = d;
    forever begin
      @(posedge clk); #1;
      if (m_last_acc) break;
      tries++;
      if (tries > 64) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    res_valid = 1'b0;
  endtask

  logic [7:0] t1_bytes [8] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h4F};
  logic [64:0] rnd;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    started = 1;
    @(negedge clk);
    check("rst_ready", res_ready, 1);
    check("rst_data", data_out_out, 0);
    check("rst_pull", pull_out, 0);
    check("rst_drop", drop_err, 0);
    @(posedge clk); #1;

    // Single frame with fixed bytes
    send(65'h0_4F80_0000_0000_0003);
    @(negedge clk);
    check("t1_latency", pull_out, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t1_byte", data_out_out, t1_bytes[k]);
      check("t1_pull", pull_out, (k == 0) ? 1 : 0);
      check("t1_sign", sign_out, 0);
    end
    @(negedge clk);
    check("t1_idle", data_out_out, 0);
    @(posedge clk); #1;

    // Back-to-back frames, sign only on the second
    send({1'b0, 64'h1716_1514_1312_1110});
    send({1'b1, 64'h2726_2524_2322_2120});
    send({1'b0, 64'h3736_3534_3332_3130});
    send({1'b0, 64'h4746_4544_4342_4140});
    idle(40);

    // Six raw writes from empty: the sixth is dropped
    for (int i = 0; i < 6; i++) begin
      res_valid = 1'b1;
      res_data  = {1'b0, 56'hA0A0_A0A0_A0A0_A0, 8'(i)};
      @(posedge clk); #1;
      if (i == 4) check("t3_ready_low", res_ready, 0);
    end
    res_valid = 1'b0;
    check("t3_drop", drop_err, 1);
    idle(50);

    // Reset while byte 3 is on the output
    send({1'b1, 64'hDEAD_BEEF_CAFE_F00D});
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t4_data", data_out_out, 0);
    check("t4_pull", pull_out, 0);
    check("t4_drop", drop_err, 0);
    check("t4_ready", res_ready, 1);
    @(posedge clk); #1;
    idle(3);
    send({1'b0, 64'h0123_4567_89AB_CDEF});
    idle(12);

    // Overfill with retries while frames drain
    for (int i = 0; i < 8; i++) send({i[0], 56'h5A5A_5A5A_5A5A_5A, 8'(i)});
    idle(80);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
      rnd = {1'($urandom_range(0, 1)), $urandom, $urandom};
      send(rnd);
    end
    idle(60);
    check("sb_empty", sb.size(), 0);
    check("coll_idle", coll, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
